// File: rtl/itrc_rob.sv
// ---------------------------------------------------------------------------
// itrc_rob -- instruction-trace completion buffer
//
// Captures one trace record per dispatched instruction in program order,
// merges out-of-order writeback results arriving on NRES completion ports
// (matched by destination tag), and streams completed records in order on a
// valid/ready interface towards the trace sink.
//
// Ports
//   clk, arst_n      clock, asynchronous active-low reset
//   flush            discard every buffered entry (dominates all events)
//   alloc_*          dispatch side: val/rdy handshake, payload, tag,
//                    pending flag and immediate rd value
//   cmpl_*           NRES completion ports, port p in slice p of each bus
//   out_*            in-order record stream: val/rdy, id, payload, rd value
//   count            registered occupancy
//   err_orphan       sticky: some completion matched no pending entry
// ---------------------------------------------------------------------------
module itrc_rob #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 8,
    parameter int NRES   = 2,
    parameter int INFO_W = 320,
    parameter int IDW    = 32,
    parameter int TAGW   = 5
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     flush,
    input  logic                     alloc_val,
    output logic                     alloc_rdy,
    input  logic [INFO_W-1:0]        alloc_info,
    input  logic [TAGW-1:0]          alloc_tag,
    input  logic                     alloc_pend,
    input  logic [XLEN-1:0]          alloc_rdval,
    input  logic [NRES-1:0]          cmpl_val,
    input  logic [NRES*TAGW-1:0]     cmpl_tag,
    input  logic [NRES*XLEN-1:0]     cmpl_data,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [IDW-1:0]           out_id,
    output logic [INFO_W-1:0]        out_info,
    output logic [XLEN-1:0]          out_rdval,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_orphan
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]    PTR_ONE = (AW+1)'(1);
    localparam logic [IDW-1:0] ID_ONE  = IDW'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]       rd_ptr, wr_ptr;
    logic [AW-1:0]     rd_idx, wr_idx;

    // Per-entry control state (reset) and payload storage (not reset).
    logic [DEPTH-1:0]  ent_val, ent_cmpl;
    logic [TAGW-1:0]   tag_mem   [DEPTH];
    logic [IDW-1:0]    id_mem    [DEPTH];
    logic [INFO_W-1:0] info_mem  [DEPTH];
    logic [XLEN-1:0]   rdval_mem [DEPTH];

    logic [IDW-1:0]    id_cnt;
    logic              full, do_alloc, do_pop;

    // Completion search results
    logic [NRES-1:0]   hit;
    logic [AW-1:0]     hit_idx [NRES];
    logic [DEPTH-1:0]  claimed;
    logic [AW-1:0]     scan_idx;
    logic [TAGW-1:0]   port_tag;

    assign rd_idx    = rd_ptr[AW-1:0];
    assign wr_idx    = wr_ptr[AW-1:0];
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign alloc_rdy = !full && !flush;
    assign do_alloc  = alloc_val && alloc_rdy;
    assign out_val   = ent_val[rd_idx] && ent_cmpl[rd_idx] && !flush;
    assign do_pop    = out_val && out_rdy;
    assign count     = wr_ptr - rd_ptr;

    assign out_id    = id_mem[rd_idx];
    assign out_info  = info_mem[rd_idx];
    assign out_rdval = rdval_mem[rd_idx];

    // Each port scans from the head (oldest) towards the tail and takes the
    // first valid, still-incomplete entry with its tag. Entries taken by a
    // lower-numbered port are masked out so equal tags on two ports retire
    // the two oldest matches. Entries written this cycle are not yet valid,
    // so a same-cycle completion cannot see them.
    // NOTE: every variable assigned in this block gets a default first, so
    // no path leaves a value held over and no latch is inferred.
    always_comb begin
        hit      = '0;
        claimed  = '0;
        scan_idx = '0;
        port_tag = '0;
        for (int p = 0; p < NRES; p++) hit_idx[p] = '0;
        for (int p = 0; p < NRES; p++) begin
            port_tag = cmpl_tag[p*TAGW +: TAGW];
            for (int k = 0; k < DEPTH; k++) begin
                scan_idx = rd_idx + AW'(k);
                if (cmpl_val[p] && !hit[p] && ent_val[scan_idx] &&
                    !ent_cmpl[scan_idx] && !claimed[scan_idx] &&
                    tag_mem[scan_idx] == port_tag) begin
                    hit[p]             = 1'b1;
                    hit_idx[p]         = scan_idx;
                    claimed[scan_idx]  = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            id_cnt     <= '0;
            ent_val    <= '0;
            ent_cmpl   <= '0;
            err_orphan <= 1'b0;
        end else if (flush) begin
            // The id counter deliberately keeps running across a flush.
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            ent_val  <= '0;
            ent_cmpl <= '0;
        end else begin
            for (int p = 0; p < NRES; p++) begin
                if (hit[p]) begin
                    ent_cmpl[hit_idx[p]] <= 1'b1;
                end else if (cmpl_val[p]) begin
                    err_orphan <= 1'b1;
                end
            end
            if (do_pop) begin
                ent_val[rd_idx] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_ONE;
            end
            if (do_alloc) begin
                ent_val[wr_idx]  <= 1'b1;
                ent_cmpl[wr_idx] <= !alloc_pend;
                wr_ptr           <= wr_ptr + PTR_ONE;
                id_cnt           <= id_cnt + ID_ONE;
            end
        end
    end

    // NOTE: payload storage has no reset; it is only observed through
    // entries whose valid bit (which is reset) is set.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            info_mem[wr_idx]  <= alloc_info;
            id_mem[wr_idx]    <= id_cnt;
            tag_mem[wr_idx]   <= alloc_tag;
            rdval_mem[wr_idx] <= (alloc_tag == '0) ? '0 : alloc_rdval;
        end
        if (!flush) begin
            for (int p = 0; p < NRES; p++) begin
                if (hit[p]) begin
                    // Writes to tag 0 (hard-wired zero register) read back as 0.
                    rdval_mem[hit_idx[p]] <= (cmpl_tag[p*TAGW +: TAGW] == '0) ?
                                             '0 : cmpl_data[p*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: tb/tb_itrc_rob.sv
// ---------------------------------------------------------------------------
// tb_itrc_rob -- self-checking bench for itrc_rob (default parameters).
// A queue-of-records reference model tracks the buffer in program order; it
// is compared against the DUT every cycle. Directed table and hand-written
// sequences add explicit expected values for the documented scenarios.
// ---------------------------------------------------------------------------
module tb_itrc_rob;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 8;
    localparam int NRES   = 2;
    localparam int INFO_W = 320;
    localparam int IDW    = 32;
    localparam int TAGW   = 5;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 arst_n = 1'b1;
    logic                 flush;
    logic                 alloc_val;
    logic                 alloc_rdy;
    logic [INFO_W-1:0]    alloc_info;
    logic [TAGW-1:0]      alloc_tag;
    logic                 alloc_pend;
    logic [XLEN-1:0]      alloc_rdval;
    logic [NRES-1:0]      cmpl_val;
    logic [NRES*TAGW-1:0] cmpl_tag;
    logic [NRES*XLEN-1:0] cmpl_data;
    logic                 out_val;
    logic                 out_rdy;
    logic [IDW-1:0]       out_id;
    logic [INFO_W-1:0]    out_info;
    logic [XLEN-1:0]      out_rdval;
    logic [CW-1:0]        count;
    logic                 err_orphan;

    itrc_rob #(
        .XLEN(XLEN), .DEPTH(DEPTH), .NRES(NRES),
        .INFO_W(INFO_W), .IDW(IDW), .TAGW(TAGW)
    ) dut (
        .clk(clk), .arst_n(arst_n), .flush(flush),
        .alloc_val(alloc_val), .alloc_rdy(alloc_rdy), .alloc_info(alloc_info),
        .alloc_tag(alloc_tag), .alloc_pend(alloc_pend), .alloc_rdval(alloc_rdval),
        .cmpl_val(cmpl_val), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
        .out_val(out_val), .out_rdy(out_rdy), .out_id(out_id),
        .out_info(out_info), .out_rdval(out_rdval),
        .count(count), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    // Reference model: records in program order, oldest at index 0.
    typedef struct {
        logic [IDW-1:0]    id;
        logic [INFO_W-1:0] info;
        logic [TAGW-1:0]   tag;
        bit                done;
        logic [XLEN-1:0]   val;
    } rec_t;

    rec_t           q[$];
    logic [IDW-1:0] m_id;
    bit             m_orphan;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit              av;
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] rdval;
        bit              e_ov;
        logic [IDW-1:0]  e_id;
        logic [XLEN-1:0] e_rv;
        int              e_cnt;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [INFO_W-1:0] act,
                         input logic [INFO_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [INFO_W-1:0] rand_info();
        logic [INFO_W-1:0] r;
        r = '0;
        for (int i = 0; i < INFO_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic idle();
        flush       = 1'b0;
        alloc_val   = 1'b0;
        alloc_pend  = 1'b0;
        alloc_tag   = '0;
        alloc_rdval = '0;
        alloc_info  = '0;
        cmpl_val    = '0;
        cmpl_tag    = '0;
        cmpl_data   = '0;
        out_rdy     = 1'b1;
    endtask

    task automatic set_alloc(input logic [TAGW-1:0] tag, input bit pend,
                             input logic [XLEN-1:0] rv);
        alloc_val   = 1'b1;
        alloc_tag   = tag;
        alloc_pend  = pend;
        alloc_rdval = rv;
        alloc_info  = rand_info();
    endtask

    task automatic set_cmpl(input int p, input logic [TAGW-1:0] tag,
                            input logic [XLEN-1:0] data);
        cmpl_val[p]                = 1'b1;
        cmpl_tag[p*TAGW +: TAGW]   = tag;
        cmpl_data[p*XLEN +: XLEN]  = data;
    endtask

    // Compare DUT outputs with what the model predicts for the current inputs.
    task automatic check_model();
        int n;
        bit e_ov;
        n    = q.size();
        e_ov = !flush && n > 0 && q[0].done;
        check("m_alloc_rdy", alloc_rdy, !flush && n < DEPTH);
        check("m_out_val", out_val, e_ov);
        check("m_count", count, n);
        check("m_err_orphan", err_orphan, m_orphan);
        if (e_ov) begin
            check("m_out_id", out_id, q[0].id);
            check("m_out_info", out_info, q[0].info);
            check("m_out_rdval", out_rdval, q[0].val);
        end
    endtask

    // Advance the model by one clock edge using the currently applied inputs.
    task automatic model_step();
        bit pop, acc;
        rec_t r;
        logic [TAGW-1:0] t;
        bit found;
        if (flush) begin
            q.delete();
            return;
        end
        pop = q.size() > 0 && q[0].done && out_rdy;
        acc = alloc_val && q.size() < DEPTH;
        for (int p = 0; p < NRES; p++) begin
            if (cmpl_val[p]) begin
                t = cmpl_tag[p*TAGW +: TAGW];
                found = 1'b0;
                for (int i = 0; i < q.size(); i++) begin
                    if (!found && !q[i].done && q[i].tag == t) begin
                        r = q[i];
                        r.done = 1'b1;
                        r.val  = (t == '0) ? '0 : cmpl_data[p*XLEN +: XLEN];
                        q[i] = r;
                        found = 1'b1;
                    end
                end
                if (!found) m_orphan = 1'b1;
            end
        end
        if (pop) void'(q.pop_front());
        if (acc) begin
            r.id   = m_id;
            r.info = alloc_info;
            r.tag  = alloc_tag;
            r.done = !alloc_pend;
            r.val  = (alloc_tag == '0) ? '0 : alloc_rdval;
            q.push_back(r);
            m_id = m_id + 1;
        end
    endtask

    // Called at a falling edge with inputs applied; returns at the next one.
    task automatic tick();
        #1;
        check_model();
        model_step();
        @(negedge clk);
    endtask

    // Assert reset (possibly mid-stream); its effect must be immediate.
    task automatic do_reset();
        arst_n = 1'b0;
        #1;
        check("rst_out_val", out_val, 0);
        check("rst_count", count, 0);
        check("rst_err_orphan", err_orphan, 0);
        idle();
        q.delete();
        m_id     = '0;
        m_orphan = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TAGW-1:0] t;
        logic [TAGW-1:0] pend_tags[$];

        idle();
        do_reset();

        // ---------------- in-order stream (table) ----------------
        tbl[0] = '{av: 1'b1, tag: 5'd1, rdval: 32'hA, e_ov: 1'b0, e_id: 32'd0, e_rv: 32'h0, e_cnt: 0};
        tbl[1] = '{av: 1'b1, tag: 5'd2, rdval: 32'hB, e_ov: 1'b1, e_id: 32'd0, e_rv: 32'hA, e_cnt: 1};
        tbl[2] = '{av: 1'b1, tag: 5'd3, rdval: 32'hC, e_ov: 1'b1, e_id: 32'd1, e_rv: 32'hB, e_cnt: 1};
        tbl[3] = '{av: 1'b0, tag: 5'd0, rdval: 32'h0, e_ov: 1'b1, e_id: 32'd2, e_rv: 32'hC, e_cnt: 1};
        tbl[4] = '{av: 1'b0, tag: 5'd0, rdval: 32'h0, e_ov: 1'b0, e_id: 32'd0, e_rv: 32'h0, e_cnt: 0};
        for (int i = 0; i < 5; i++) begin
            idle();
            if (tbl[i].av) set_alloc(tbl[i].tag, 1'b0, tbl[i].rdval);
            #1;
            check($sformatf("tbl%0d_out_val", i), out_val, tbl[i].e_ov);
            check($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
            if (tbl[i].e_ov) begin
                check($sformatf("tbl%0d_out_id", i), out_id, tbl[i].e_id);
                check($sformatf("tbl%0d_out_rdval", i), out_rdval, tbl[i].e_rv);
            end
            tick();
        end

        // ---------------- out-of-order completion ----------------
        do_reset();
        idle(); set_alloc(5'd5, 1'b1, 32'h0);  tick();
        idle(); set_alloc(5'd6, 1'b0, 32'h66); tick();
        for (int i = 0; i < 2; i++) begin
            idle(); #1;
            check("ooo_wait_out_val", out_val, 0);
            tick();
        end
        idle(); set_cmpl(0, 5'd5, 32'h55); #1;
        check("ooo_cmpl_cycle_out_val", out_val, 0);
        tick();
        idle(); #1;
        check("ooo_first_out_val", out_val, 1);
        check("ooo_first_id", out_id, 0);
        check("ooo_first_rdval", out_rdval, 32'h55);
        tick();
        idle(); #1;
        check("ooo_second_out_val", out_val, 1);
        check("ooo_second_id", out_id, 1);
        check("ooo_second_rdval", out_rdval, 32'h66);
        tick();

        // ---------------- dual port, same tag ----------------
        do_reset();
        idle(); set_alloc(5'd7, 1'b1, 32'h0); tick();
        idle(); set_alloc(5'd7, 1'b1, 32'h0); tick();
        idle(); set_cmpl(0, 5'd7, 32'h1); set_cmpl(1, 5'd7, 32'h2); tick();
        idle(); #1;
        check("dual_old_id", out_id, 0);
        check("dual_old_rdval", out_rdval, 32'h1);
        tick();
        idle(); #1;
        check("dual_young_id", out_id, 1);
        check("dual_young_rdval", out_rdval, 32'h2);
        check("dual_err_orphan", err_orphan, 0);
        tick();

        // ---------------- full / backpressure ----------------
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            idle(); out_rdy = 1'b0; set_alloc(5'(i + 1), 1'b0, 32'(i)); #1;
            check("full_fill_alloc_rdy", alloc_rdy, 1);
            tick();
        end
        idle(); out_rdy = 1'b0; set_alloc(5'd9, 1'b0, 32'h99); #1;
        check("full_alloc_rdy", alloc_rdy, 0);
        check("full_count", count, DEPTH);
        tick();
        idle(); out_rdy = 1'b1; set_alloc(5'd9, 1'b0, 32'h99); #1;
        check("full_pop_alloc_rdy", alloc_rdy, 0);
        check("full_pop_id", out_id, 0);
        tick();
        idle(); out_rdy = 1'b0; set_alloc(5'd9, 1'b0, 32'h99); #1;
        check("full_after_pop_alloc_rdy", alloc_rdy, 1);
        check("full_after_pop_count", count, DEPTH - 1);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            idle(); #1;
            if (i == DEPTH - 1) begin
                check("full_ninth_id", out_id, 8);
                check("full_ninth_rdval", out_rdval, 32'h99);
            end
            tick();
        end

        // ---------------- orphan and tag 0 ----------------
        do_reset();
        idle(); set_cmpl(0, 5'd9, 32'h1234); tick();
        idle(); #1;
        check("orphan_set", err_orphan, 1);
        set_alloc(5'd0, 1'b1, 32'h0); tick();
        idle(); set_cmpl(1, 5'd0, 32'hFFFF); tick();
        idle(); #1;
        check("x0_out_val", out_val, 1);
        check("x0_rdval", out_rdval, 0);
        check("orphan_sticky", err_orphan, 1);
        tick();

        // ---------------- flush mid-stream ----------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); set_alloc(5'(i + 1), 1'b1, 32'h0); tick();
        end
        idle(); flush = 1'b1; set_alloc(5'd8, 1'b0, 32'h8); set_cmpl(0, 5'd1, 32'h11); #1;
        check("flush_alloc_rdy", alloc_rdy, 0);
        check("flush_out_val", out_val, 0);
        tick();
        idle(); #1;
        check("flush_count", count, 0);
        check("flush_after_out_val", out_val, 0);
        check("flush_err_orphan", err_orphan, 0);
        set_alloc(5'd3, 1'b0, 32'h33); tick();
        idle(); #1;
        check("flush_next_out_val", out_val, 1);
        check("flush_next_id", out_id, 4);
        check("flush_next_rdval", out_rdval, 32'h33);
        tick();

        // ---------------- randomized traffic against the model ----------------
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            idle();
            flush   = ($urandom_range(0, 49) == 0);
            out_rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 6)
                set_alloc(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
            pend_tags.delete();
            for (int i = 0; i < q.size(); i++)
                if (!q[i].done) pend_tags.push_back(q[i].tag);
            for (int p = 0; p < NRES; p++) begin
                if ($urandom_range(0, 3) == 0) begin
                    t = 5'($urandom_range(0, 7));
                    if (pend_tags.size() > 0 && $urandom_range(0, 3) != 0)
                        t = pend_tags[$urandom_range(0, pend_tags.size() - 1)];
                    set_cmpl(p, t, $urandom);
                end
            end
            tick();
        end

        // Reset with traffic still buffered.
        for (int i = 0; i < 3; i++) begin
            idle(); set_alloc(5'd2, 1'b0, 32'h22); tick();
        end
        do_reset();
        idle(); #1;
        check("post_reset_out_val", out_val, 0);
        check("post_reset_count", count, 0);
        set_alloc(5'd1, 1'b0, 32'h1); tick();
        idle(); #1;
        check("post_reset_id", out_id, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
